// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the issue scheduler.
//   exec_class_t  : decoded micro-op execution class (3 bits)
//   sched_state_t : serialisation FSM state
//   DEF_*         : default latency parameters
//   cnt_width()   : width of a countdown able to hold the longest hazard window
package issue_scheduler_pkg;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_MUL    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_CSR    = 3'd6,
        CLS_FENCE  = 3'd7
    } exec_class_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_t;

    localparam int DEF_LD_USE_STALL = 1;
    localparam int DEF_MUL_LATENCY  = 3;

    // Countdown must represent max(load-use window, MUL window).
    function automatic int cnt_width(input int ld_use, input int mul_lat);
        int m;
        m = (ld_use > (mul_lat - 1)) ? ld_use : (mul_lat - 1);
        return $clog2(m + 1);
    endfunction

    // CSR and FENCE execute alone: everything older must have retired.
    function automatic logic is_serial(input exec_class_t c);
        return (c == CLS_CSR) || (c == CLS_FENCE);
    endfunction

endpackage

// File: rtl/issue_scheduler_reg_scoreboard.sv
// Register scoreboard: one countdown per architectural register x1..x31.
// A nonzero count means the register's pending result is not yet forwardable.
// Ports:
//   clk, rst             : clock, async active-high reset (all counts to 0)
//   i_set_en/addr/val    : load a countdown (overrides that cycle's decrement)
//   i_a_addr/i_a_used    : hazard read port A  -> o_a_busy
//   i_b_addr/i_b_used    : hazard read port B  -> o_b_busy
//   o_all_clear          : no register has a pending result
module reg_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set_en,
    input  logic [4:0]       i_set_addr,
    input  logic [CNT_W-1:0] i_set_val,
    input  logic [4:0]       i_a_addr,
    input  logic             i_a_used,
    input  logic [4:0]       i_b_addr,
    input  logic             i_b_used,
    output logic             o_a_busy,
    output logic             o_b_busy,
    output logic             o_all_clear
);

    logic [CNT_W-1:0] r_cnt [1:31];
    logic [31:0]      w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (i_set_en && (i_set_addr == 5'(i))) begin
                    r_cnt[i] <= i_set_val;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // x0 has no storage and is never busy.
    always_comb begin
        w_busy    = '0;
        for (int i = 1; i < 32; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    assign o_a_busy    = i_a_used & w_busy[i_a_addr];
    assign o_b_busy    = i_b_used & w_busy[i_b_addr];
    assign o_all_clear = ~|w_busy;

endmodule

// File: rtl/issue_scheduler.sv
// Issue controller between decode and execute.
// Holds the decode-stage micro-op until it can issue safely: load-use and MUL
// data hazards (scoreboard), MUL structural hazard (non-pipelined unit) and
// CSR/FENCE serialisation (drain, issue alone, wait for completion).
// ALU results are fully forwarded, so ALU producers never cause a stall.
//
// Handshake: ex_valid is driven combinationally from the current id_* fields
// and registered hazard state; a micro-op is issued in any cycle where
// ex_valid & ex_ready. id_ready pulses in the cycle the decode op is consumed,
// either by issue or by being squashed under ex_redirect.
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   id_*                : decoded micro-op (valid, class, sources, destination)
//   id_ready            : decode op consumed this cycle
//   ex_valid/ex_ready   : issue handshake to execute
//   ex_redirect         : older op redirects fetch; squash decode op
//   lsu_idle            : no loads/stores outstanding
//   serial_done         : issued CSR/FENCE completed
//   flush_id            : flush request to decode/fetch
//   o_dbg_state         : current FSM state
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int LD_USE_STALL = DEF_LD_USE_STALL,
    parameter int MUL_LATENCY  = DEF_MUL_LATENCY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    output logic         id_ready,
    input  logic [2:0]   id_class,
    input  logic [4:0]   id_rs1_addr,
    input  logic         id_rs1_used,
    input  logic [4:0]   id_rs2_addr,
    input  logic         id_rs2_used,
    input  logic [4:0]   id_rd_addr,
    input  logic         id_rd_en,
    output logic         ex_valid,
    input  logic         ex_ready,
    input  logic         ex_redirect,
    input  logic         lsu_idle,
    input  logic         serial_done,
    output logic         flush_id,
    output sched_state_t o_dbg_state
);

    localparam int CNT_W = cnt_width(LD_USE_STALL, MUL_LATENCY);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_mul_cnt;

    exec_class_t      w_cls;
    logic             w_serial;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_raw;
    logic             w_struct;
    logic             w_all_clear;
    logic             w_ex_valid;
    logic             w_id_ready;
    logic             w_issue;
    logic             w_sb_set_en;
    logic [CNT_W-1:0] w_sb_set_val;

    assign w_cls    = exec_class_t'(id_class);
    assign w_serial = is_serial(w_cls);
    assign w_raw    = w_rs1_busy | w_rs2_busy;
    assign w_struct = (w_cls == CLS_MUL) && (r_mul_cnt != '0);

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_set_en    (w_sb_set_en),
        .i_set_addr  (id_rd_addr),
        .i_set_val   (w_sb_set_val),
        .i_a_addr    (id_rs1_addr),
        .i_a_used    (id_rs1_used),
        .i_b_addr    (id_rs2_addr),
        .i_b_used    (id_rs2_used),
        .o_a_busy    (w_rs1_busy),
        .o_b_busy    (w_rs2_busy),
        .o_all_clear (w_all_clear)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (!ex_redirect && id_valid && w_serial) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ex_redirect) begin
                    w_state_nxt = ST_RUN;
                end else if (w_all_clear && (r_mul_cnt == '0) && lsu_idle) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ex_redirect) begin
                    w_state_nxt = ST_RUN;
                end else if (ex_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The serial op is already in execute; a redirect cannot
                // cancel it, so only its completion leaves this state.
                if (serial_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ex_valid = 1'b0;
        w_id_ready = 1'b0;
        case (r_state)
            ST_RUN:   w_ex_valid = id_valid & ~w_serial & ~w_raw & ~w_struct & ~ex_redirect;
            ST_ISSUE: w_ex_valid = id_valid & ~ex_redirect;
            default:  w_ex_valid = 1'b0;
        endcase
        if (r_state != ST_WAIT) begin
            w_id_ready = (w_ex_valid & ex_ready) | (id_valid & ex_redirect);
        end
        if (rst) begin
            w_ex_valid = 1'b0;
            w_id_ready = 1'b0;
        end
    end

    assign w_issue     = w_ex_valid & ex_ready;
    assign w_sb_set_en = w_issue & id_rd_en & (id_rd_addr != 5'd0);

    always_comb begin
        w_sb_set_val = '0;
        case (w_cls)
            CLS_LOAD: w_sb_set_val = CNT_W'(LD_USE_STALL);
            CLS_MUL:  w_sb_set_val = CNT_W'(MUL_LATENCY - 1);
            default:  w_sb_set_val = '0;
        endcase
    end

    // MUL unit occupancy: busy until its result becomes forwardable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_cnt <= '0;
        end else if (w_issue && (w_cls == CLS_MUL)) begin
            r_mul_cnt <= CNT_W'(MUL_LATENCY - 1);
        end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - CNT_W'(1);
        end
    end

    assign ex_valid    = w_ex_valid;
    assign id_ready    = w_id_ready;
    assign flush_id    = ex_redirect;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_issue_scheduler.sv
// Cycle-by-cycle vector bench for issue_scheduler.
// Each vector holds one cycle of inputs plus the outputs expected in that
// cycle (state, ex_valid, id_ready, flush_id).
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic         clk;
  logic         rst;
  logic         id_valid;
  logic         id_ready;
  logic [2:0]   id_class;
  logic [4:0]   id_rs1_addr;
  logic         id_rs1_used;
  logic [4:0]   id_rs2_addr;
  logic         id_rs2_used;
  logic [4:0]   id_rd_addr;
  logic         id_rd_en;
  logic         ex_valid;
  logic         ex_ready;
  logic         ex_redirect;
  logic         lsu_idle;
  logic         serial_done;
  logic         flush_id;
  sched_state_t dbg_state;

  issue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_class    (id_class),
    .id_rs1_addr (id_rs1_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_addr (id_rs2_addr),
    .id_rs2_used (id_rs2_used),
    .id_rd_addr  (id_rd_addr),
    .id_rd_en    (id_rd_en),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_redirect (ex_redirect),
    .lsu_idle    (lsu_idle),
    .serial_done (serial_done),
    .flush_id    (flush_id),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] cls;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rden;
    logic       vld;
    logic       rdy;
    logic       redir;
    logic       idle;
    logic       sdone;
    logic [4:0] exp;  // {state[1:0], ex_valid, id_ready, flush_id}
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         total;
  int         bad;

  localparam logic [1:0] S_RUN = 2'd0, S_DRN = 2'd1, S_ISS = 2'd2, S_WT = 2'd3;
  localparam logic [2:0] C_ALU = 3'd0, C_MUL = 3'd1, C_LD = 3'd2, C_CSR = 3'd6, C_FEN = 3'd7;

  function void add(input logic [2:0] cls, input int rs1, input logic u1,
                    input int rs2, input logic u2, input int rd, input logic rden,
                    input logic vld, input logic rdy, input logic redir,
                    input logic idle, input logic sdone,
                    input logic [1:0] st, input logic ev, input logic ir, input logic fl);
    vec_t v;
    v.cls = cls; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.rd = 5'(rd); v.rden = rden; v.vld = vld; v.rdy = rdy; v.redir = redir;
    v.idle = idle; v.sdone = sdone; v.exp = {st, ev, ir, fl};
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    id_class    = v.cls;
    id_rs1_addr = v.rs1;
    id_rs1_used = v.u1;
    id_rs2_addr = v.rs2;
    id_rs2_used = v.u2;
    id_rd_addr  = v.rd;
    id_rd_en    = v.rden;
    id_valid    = v.vld;
    ex_ready    = v.rdy;
    ex_redirect = v.redir;
    lsu_idle    = v.idle;
    serial_done = v.sdone;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".state"},    32'(dbg_state), 32'(e[4:3]));
      chk({tag, ".ex_valid"}, 32'(ex_valid),  32'(e[2]));
      chk({tag, ".id_ready"}, 32'(id_ready),  32'(e[1]));
      chk({tag, ".flush_id"}, 32'(flush_id),  32'(e[0]));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    // Load-use: LOAD x5, then ADD x6,x5,x1 stalls one cycle.
    add(C_LD,  1,1, 0,0,  5,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU, 5,1, 1,1,  6,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_ALU, 5,1, 1,1,  6,1, 1,1,0,1,0, S_RUN,1,1,0);
    // MUL x7; second MUL x8 waits on the unit, issues at t+3.
    add(C_MUL, 1,1, 2,1,  7,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_MUL, 1,1, 2,1,  8,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_MUL, 1,1, 2,1,  8,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_MUL, 1,1, 2,1,  8,1, 1,1,0,1,0, S_RUN,1,1,0);
    // ADD using x8 issues three cycles after the MUL.
    add(C_ALU, 8,1, 0,0,  9,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_ALU, 0,0, 8,1,  9,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_ALU, 8,1, 0,0,  9,1, 1,1,0,1,0, S_RUN,1,1,0);
    // Backpressure: no handshake means no scoreboard update.
    add(C_LD,  1,1, 0,0, 10,1, 1,0,0,1,0, S_RUN,1,0,0);
    add(C_ALU,10,1, 0,0, 11,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_LD,  1,1, 0,0, 12,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU,12,1, 0,0, 11,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_ALU,12,1, 0,0, 11,1, 1,1,0,1,0, S_RUN,1,1,0);
    // ALU->ALU forwarding, x0 never marked, unused source ignored.
    add(C_ALU, 1,1, 0,0,  3,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU, 3,1, 3,1,  4,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_LD,  1,1, 0,0,  0,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU, 0,1, 0,1,  4,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_LD,  1,1, 0,0, 13,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU,13,0,13,0, 14,0, 1,1,0,1,0, S_RUN,1,1,0);
    // CSR behind a LOAD: drain 4 cycles on lsu busy, issue, wait.
    add(C_LD,  1,1, 0,0, 14,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,0,0, S_RUN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,0,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,0,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,0,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,0,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,1,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,0,0,1,0, S_ISS,1,0,0);
    add(C_CSR, 1,1, 0,0, 15,1, 1,1,0,1,0, S_ISS,1,1,0);
    add(C_ALU,15,1, 0,0, 16,1, 1,1,0,1,0, S_WT, 0,0,0);
    add(C_ALU,15,1, 0,0, 16,1, 1,1,1,1,0, S_WT, 0,0,1);
    add(C_ALU,15,1, 0,0, 16,1, 1,1,0,1,1, S_WT, 0,0,0);
    add(C_ALU,15,1, 0,0, 16,1, 1,1,0,1,0, S_RUN,1,1,0);
    // FENCE redirected while in ISSUE: dropped, back to RUN.
    add(C_FEN, 0,0, 0,0,  0,0, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_FEN, 0,0, 0,0,  0,0, 1,1,0,1,0, S_DRN,0,0,0);
    add(C_FEN, 0,0, 0,0,  0,0, 1,1,1,1,0, S_ISS,0,1,1);
    add(C_ALU, 0,0, 0,0,  0,0, 0,1,0,1,0, S_RUN,0,0,0);
    // Redirect on a stalled dependent op; scoreboard still drains.
    add(C_LD,  1,1, 0,0, 16,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_ALU,16,1, 0,0, 17,1, 1,1,1,1,0, S_RUN,0,1,1);
    add(C_ALU,16,1, 0,0, 17,1, 1,1,0,1,0, S_RUN,1,1,0);
    // Redirect and serial_done together in WAIT -> RUN.
    add(C_CSR, 1,1, 0,0, 18,1, 1,1,0,1,0, S_RUN,0,0,0);
    add(C_CSR, 1,1, 0,0, 18,1, 1,1,0,1,0, S_DRN,0,0,0);
    add(C_CSR, 1,1, 0,0, 18,1, 1,1,0,1,0, S_ISS,1,1,0);
    add(C_ALU, 1,1, 0,0, 19,1, 1,1,1,1,1, S_WT, 0,0,1);
    add(C_ALU, 1,1, 0,0, 19,1, 1,1,0,1,0, S_RUN,1,1,0);
    // Redirect in DRAIN.
    add(C_CSR, 1,1, 0,0, 18,1, 1,1,0,0,0, S_RUN,0,0,0);
    add(C_CSR, 1,1, 0,0, 18,1, 1,1,1,0,0, S_DRN,0,1,1);
    add(C_ALU, 1,1, 0,0, 19,1, 1,1,0,1,0, S_RUN,1,1,0);
    // Setup for reset-in-DRAIN: MUL x5, then CSR enters DRAIN with count[x5]=1.
    add(C_MUL, 1,1, 2,1,  5,1, 1,1,0,1,0, S_RUN,1,1,0);
    add(C_CSR, 1,1, 0,0, 20,1, 1,1,0,0,0, S_RUN,0,0,0);

    // Reset state with a valid op presented.
    rst = 1'b1;
    v = vecs[0];
    drive(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.ex_valid", 32'(ex_valid), 32'd0);
    chk("reset.id_ready", 32'(id_ready), 32'd0);
    chk("reset.state",    32'(dbg_state), 32'(S_RUN));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      #1;
      check_out($sformatf("v%0d", i));
    end

    // Reset asserted mid-DRAIN while count[x5]=1.
    @(negedge clk);
    v = vecs[vecs.size()-1];
    drive(v);
    exp_q.push_back({S_DRN, 1'b0, 1'b0, 1'b0});
    #1;
    check_out("rst_drain.pre");
    #1;
    rst = 1'b1;
    exp_q.push_back({S_RUN, 1'b0, 1'b0, 1'b0});
    #1;
    check_out("rst_drain.in");
    @(negedge clk);
    rst = 1'b0;
    v.cls = C_ALU; v.rs1 = 5'd5; v.u1 = 1'b1; v.rs2 = 5'd5; v.u2 = 1'b1;
    v.rd = 5'd21; v.idle = 1'b1;
    drive(v);
    exp_q.push_back({S_RUN, 1'b1, 1'b1, 1'b0});
    #1;
    check_out("rst_drain.use_x5");
    // MUL unit is free again after reset.
    @(negedge clk);
    v.cls = C_MUL; v.rd = 5'd22;
    drive(v);
    exp_q.push_back({S_RUN, 1'b1, 1'b1, 1'b0});
    #1;
    check_out("rst_drain.mul");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover expected entries=%0d", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
